// File: rtl/cu_fsm_if.sv
// cu_fsm_if -- instruction-decode / control-strobe bundle of the multicycle
// control unit.
//   master : owned by the datapath side; drives intr, opcode, func3 and
//            receives the control strobes.
//   slave  : owned by cu_fsm; samples intr/opcode/func3 and drives
//            PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE,
//            int_taken, mret_exec.
interface cu_fsm_if;
  logic       intr;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       PCWrite;
  logic       regWrite;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       reset;
  logic       csr_WE;
  logic       int_taken;
  logic       mret_exec;

  modport master (
    output intr, opcode, func3,
    input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
           csr_WE, int_taken, mret_exec
  );

  modport slave (
    input  intr, opcode, func3,
    output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
           csr_WE, int_taken, mret_exec
  );
endinterface

// File: rtl/cu_fsm.sv
// cu_fsm -- multicycle control unit FSM (INIT, FETCH, EXEC, WB, INTR).
// Ports:
//   CLK  : system clock, all state changes on the rising edge.
//   RST  : synchronous active-high reset; forces INIT and suppresses every
//          architectural write strobe in the same cycle.
//   bus  : cu_fsm_if.slave -- intr/opcode/func3 in, control strobes out.
// Parameter:
//   INTR_EN : 1 = interrupt entry enabled, 0 = intr is ignored.
// Outputs are purely combinational from state, opcode, func3 and RST.
module cu_fsm #(
  parameter bit INTR_EN = 1'b1
) (
  input  logic     CLK,
  input  logic     RST,
  cu_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RG3    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Power-up value gives INIT before the first reset edge on FPGA targets.
  state_e state_reg = ST_INIT;
  state_e state_next;

  logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
  logic dp_reset, csr_we, int_taken, mret_exec;
  logic intr_req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_we2    = 1'b0;
    mem_rden1  = 1'b0;
    mem_rden2  = 1'b0;
    dp_reset   = 1'b0;
    csr_we     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;
    state_next = state_reg;
    intr_req   = bus.intr & INTR_EN;

    case (state_reg)
      ST_INIT: begin
        dp_reset   = 1'b1;
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        mem_rden1  = 1'b1;
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        // intr is only honoured here for single-cycle-execute instructions;
        // a LOAD defers it to WB so the load is never split.
        state_next = intr_req ? ST_INTR : ST_FETCH;
        pc_write   = 1'b1;
        case (bus.opcode)
          OP_LOAD: begin
            mem_rden2  = 1'b1;
            pc_write   = 1'b0;
            state_next = ST_WB;
          end
          OP_STORE: mem_we2 = 1'b1;
          OP_BRANCH: ; // PC update only
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3:
            reg_write = 1'b1;
          OP_SYSTEM: begin
            case (bus.func3)
              3'b000: mret_exec = 1'b1;
              3'b001, 3'b010, 3'b011: begin
                reg_write = 1'b1;
                csr_we    = 1'b1;
              end
              default: ; // unsupported SYSTEM op is skipped
            endcase
          end
          default: ; // unknown opcode is skipped
        endcase
      end

      ST_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        state_next = intr_req ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        // Always return to FETCH so a held intr cannot re-enter back to back.
        int_taken  = 1'b1;
        pc_write   = 1'b1;
        state_next = ST_FETCH;
      end

      default: state_next = ST_INIT;
    endcase

    // A reset landing mid-instruction must not commit anything.
    if (RST) begin
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_we2   = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
    end
  end

  assign bus.PCWrite   = pc_write;
  assign bus.regWrite  = reg_write;
  assign bus.memWE2    = mem_we2;
  assign bus.memRDEN1  = mem_rden1;
  assign bus.memRDEN2  = mem_rden2;
  assign bus.reset     = dp_reset;
  assign bus.csr_WE    = csr_we;
  assign bus.int_taken = int_taken;
  assign bus.mret_exec = mret_exec;

endmodule

// File: tb/tb_cu_fsm.sv
// Testbench for cu_fsm. Two instances run in lock-step on the same stimulus:
// dut_a with interrupts enabled, dut_b with INTR_EN=0. Each cycle the
// expected strobe vectors of both are queued; the observed vectors are
// captured on the falling edge and compared by each test task.
// Vector bit order: PCWrite regWrite memWE2 memRDEN1 memRDEN2 reset
//                   csr_WE int_taken mret_exec
module tb_cu_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cu_fsm_if if_a ();
  cu_fsm_if if_b ();

  cu_fsm #(.INTR_EN(1'b1)) dut_a (.CLK(clk), .RST(rst), .bus(if_a));
  cu_fsm #(.INTR_EN(1'b0)) dut_b (.CLK(clk), .RST(rst), .bus(if_b));

  localparam logic [8:0] E_ZERO  = 9'b000000000;
  localparam logic [8:0] E_INIT  = 9'b000001000;
  localparam logic [8:0] E_FETCH = 9'b000100000;
  localparam logic [8:0] E_ALU   = 9'b110000000;
  localparam logic [8:0] E_LOAD  = 9'b000010000;
  localparam logic [8:0] E_WB    = 9'b110000000;
  localparam logic [8:0] E_INTR  = 9'b100000010;
  localparam logic [8:0] E_STORE = 9'b101000000;
  localparam logic [8:0] E_MRET  = 9'b100000001;
  localparam logic [8:0] E_CSR   = 9'b110000100;
  localparam logic [8:0] E_SKIP  = 9'b100000000;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // One clock of stimulus: inputs change just after the rising edge,
  // expectation is queued, outputs are captured on the falling edge.
  task automatic cycle(input logic r, input logic i, input logic [6:0] op,
                       input logic [2:0] f3, input logic [8:0] ea,
                       input logic [8:0] eb);
    @(posedge clk);
    #1;
    rst = r;
    if_a.intr = i;  if_a.opcode = op;  if_a.func3 = f3;
    if_b.intr = i;  if_b.opcode = op;  if_b.func3 = f3;
    exp_q.push_back({ea, eb});
    @(negedge clk);
    obs_q.push_back({if_a.PCWrite, if_a.regWrite, if_a.memWE2, if_a.memRDEN1,
                     if_a.memRDEN2, if_a.reset, if_a.csr_WE, if_a.int_taken,
                     if_a.mret_exec,
                     if_b.PCWrite, if_b.regWrite, if_b.memWE2, if_b.memRDEN1,
                     if_b.memRDEN2, if_b.reset, if_b.csr_WE, if_b.int_taken,
                     if_b.mret_exec});
  endtask

  // Bring the two instances back into step after an interrupt diverged them;
  // leaves both in FETCH at the next cycle.
  task automatic resync(input logic [8:0] ea, input logic [8:0] eb,
                        input logic [6:0] op);
    cycle(1'b1, 1'b0, op, 3'b000, ea, eb);
    cycle(1'b0, 1'b0, op, 3'b000, E_INIT, E_INIT);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 7'b0000000, 3'b000, E_INIT, E_INIT);
    cycle(1'b1, 1'b0, 7'b0000000, 3'b000, E_INIT, E_INIT);
    cycle(1'b0, 1'b0, 7'b0000000, 3'b000, E_INIT, E_INIT);
    cycle(1'b0, 1'b0, 7'b0000000, 3'b000, E_FETCH, E_FETCH);
    cycle(1'b0, 1'b0, 7'b0000000, 3'b000, E_SKIP, E_SKIP);
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [17:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset cycle %0d: got %b required %b", k, o, e);
      end else $display("ok reset cycle %0d: %b", k, o);
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [7];
    logic [8:0] ex  [7];
    ops = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111,
            7'b1101111, 7'b1100111, 7'b1100011};
    ex  = '{E_ALU, E_ALU, E_ALU, E_ALU, E_ALU, E_ALU, E_SKIP};
    for (int j = 0; j < 7; j++) begin
      cycle(1'b0, 1'b0, ops[j], 3'b000, E_FETCH, E_FETCH);
      cycle(1'b0, 1'b0, ops[j], 3'b000, ex[j], ex[j]);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [17:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL alu cycle %0d: got %b required %b", k, o, e);
      end else $display("ok alu cycle %0d: %b", k, o);
    end
  endtask

  task automatic test_load_intr();
    cycle(1'b0, 1'b1, OP_LOAD, 3'b000, E_FETCH, E_FETCH);
    cycle(1'b0, 1'b1, OP_LOAD, 3'b000, E_LOAD,  E_LOAD);
    cycle(1'b0, 1'b1, OP_LOAD, 3'b000, E_WB,    E_WB);
    cycle(1'b0, 1'b1, OP_LOAD, 3'b000, E_INTR,  E_FETCH);
    cycle(1'b0, 1'b1, OP_LOAD, 3'b000, E_FETCH, E_LOAD);
    // a: EXEC of LOAD under reset (read enable not a write); b: WB, writes killed
    resync(E_LOAD, E_ZERO, OP_LOAD);
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [17:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL load_intr cycle %0d: got %b required %b", k, o, e);
      end else $display("ok load_intr cycle %0d: %b", k, o);
    end
  endtask

  task automatic test_store_intr();
    // intr only during FETCH is ignored
    cycle(1'b0, 1'b1, OP_IMM,   3'b000, E_FETCH, E_FETCH);
    cycle(1'b0, 1'b0, OP_IMM,   3'b000, E_ALU,   E_ALU);
    // intr rises in EXEC of a STORE
    cycle(1'b0, 1'b0, OP_STORE, 3'b000, E_FETCH, E_FETCH);
    cycle(1'b0, 1'b1, OP_STORE, 3'b000, E_STORE, E_STORE);
    cycle(1'b0, 1'b0, OP_STORE, 3'b000, E_INTR,  E_FETCH);
    resync(E_FETCH, E_ZERO, 7'b0000000);
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [17:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL store_intr cycle %0d: got %b required %b", k, o, e);
      end else $display("ok store_intr cycle %0d: %b", k, o);
    end
  endtask

  task automatic test_system();
    logic [2:0] f3s [6];
    logic [8:0] ex  [6];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    ex  = '{E_MRET, E_CSR, E_CSR, E_CSR, E_SKIP, E_SKIP};
    for (int j = 0; j < 6; j++) begin
      cycle(1'b0, 1'b0, OP_SYS, f3s[j], E_FETCH, E_FETCH);
      cycle(1'b0, 1'b0, OP_SYS, f3s[j], ex[j], ex[j]);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [17:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL system cycle %0d: got %b required %b", k, o, e);
      end else $display("ok system cycle %0d: %b", k, o);
    end
  endtask

  task automatic test_reset_mid_store();
    cycle(1'b0, 1'b0, OP_STORE, 3'b000, E_FETCH, E_FETCH);
    cycle(1'b1, 1'b1, OP_STORE, 3'b000, E_ZERO,  E_ZERO);
    cycle(1'b0, 1'b0, OP_STORE, 3'b000, E_INIT,  E_INIT);
    cycle(1'b0, 1'b0, OP_STORE, 3'b000, E_FETCH, E_FETCH);
    cycle(1'b0, 1'b0, OP_STORE, 3'b000, E_STORE, E_STORE);
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [17:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid cycle %0d: got %b required %b", k, o, e);
      end else $display("ok reset_mid cycle %0d: %b", k, o);
    end
  endtask

  task automatic test_back_to_back();
    // intr held high across an ALU instruction: entry, then a full
    // FETCH+EXEC before the next entry
    cycle(1'b0, 1'b1, OP_IMM, 3'b000, E_FETCH, E_FETCH);
    cycle(1'b0, 1'b1, OP_IMM, 3'b000, E_ALU,   E_ALU);
    cycle(1'b0, 1'b1, OP_IMM, 3'b000, E_INTR,  E_FETCH);
    cycle(1'b0, 1'b1, OP_IMM, 3'b000, E_FETCH, E_ALU);
    cycle(1'b0, 1'b1, OP_IMM, 3'b000, E_ALU,   E_FETCH);
    cycle(1'b0, 1'b1, OP_IMM, 3'b000, E_INTR,  E_ALU);
    resync(E_FETCH, E_FETCH, OP_IMM);
    for (int k = 0; exp_q.size() > 0; k++) begin
      logic [17:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", k, o, e);
      end else $display("ok back_to_back cycle %0d: %b", k, o);
    end
  endtask

  initial begin
    if_a.intr = 1'b0; if_a.opcode = '0; if_a.func3 = '0;
    if_b.intr = 1'b0; if_b.opcode = '0; if_b.func3 = '0;
    test_reset();
    test_alu_ops();
    test_load_intr();
    test_store_intr();
    test_system();
    test_back_to_back();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
